// File: rtl/snoop_cache_ctrl.sv
// snoop_cache_ctrl: direct-mapped write-back/write-allocate MESI snooping cache, one word per line.
// CACHE_EXCLUSIVE_EN enables the E state; without it the controller runs plain MSI.
module snoop_cache_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int NUM_LINES = 16,
   parameter int PROC_ID_W = 2,
   parameter int PROC_ID   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_req,
   input  logic                 cpu_wr,
   input  logic [ADDR_W-1:0]    cpu_addr,
   input  logic [DATA_W-1:0]    cpu_wdata,
   output logic                 cpu_ready,
   output logic [DATA_W-1:0]    cpu_rdata,
   output logic                 bus_req,
   input  logic                 bus_gnt,
   output logic [1:0]           bus_cmd,
   output logic [ADDR_W-1:0]    bus_addr,
   output logic [DATA_W-1:0]    bus_wdata,
   output logic [PROC_ID_W-1:0] bus_proc_id,
   input  logic                 bus_done,
   input  logic [DATA_W-1:0]    bus_rdata,
   input  logic                 bus_shared_in,
   input  logic                 snoop_valid,
   input  logic [1:0]           snoop_cmd,
   input  logic [ADDR_W-1:0]    snoop_addr,
   input  logic [PROC_ID_W-1:0] snoop_proc_id,
   output logic                 snoop_shared,
   output logic                 snoop_flush,
   output logic [DATA_W-1:0]    snoop_data,
   output logic [1:0]           state_dbg
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam logic [1:0] LI = 2'd0, LS = 2'd1, LE = 2'd2, LM = 2'd3;
   localparam logic [1:0] CMD_RD = 2'd1, CMD_RDX = 2'd2, CMD_WRBK = 2'd3;
`ifdef CACHE_EXCLUSIVE_EN
   localparam logic EXCL = 1'b1;
`else
   localparam logic EXCL = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WRBK, FETCH, RESP} fsmState_t;

   fsmState_t fsm;
   logic [1:0]        lineState [NUM_LINES];
   logic [TAG_W-1:0]  tagMem    [NUM_LINES];
   logic [DATA_W-1:0] dataMem   [NUM_LINES];

   logic [IDX_W-1:0] cIdx, sIdx;
   logic [TAG_W-1:0] cTag, sTag;
   logic             cHit, snoopAct, snoopBlock;

   assign cIdx = cpu_addr[IDX_W-1:0];
   assign cTag = cpu_addr[ADDR_W-1:IDX_W];
   assign sIdx = snoop_addr[IDX_W-1:0];
   assign sTag = snoop_addr[ADDR_W-1:IDX_W];
   assign cHit = lineState[cIdx] != LI && tagMem[cIdx] == cTag;

   // Only foreign BusRd/BusRdX hitting a valid line have any effect here.
   assign snoopAct = snoop_valid && snoop_proc_id != PROC_ID_W'(PROC_ID) &&
                     (snoop_cmd == CMD_RD || snoop_cmd == CMD_RDX) &&
                     lineState[sIdx] != LI && tagMem[sIdx] == sTag;
   assign snoopBlock   = snoopAct && sIdx == cIdx;
   assign snoop_shared = snoopAct;
   assign snoop_flush  = snoopAct && lineState[sIdx] == LM;
   assign snoop_data   = snoop_flush ? dataMem[sIdx] : '0;
   assign state_dbg    = lineState[cIdx];
   assign bus_proc_id  = bus_req ? PROC_ID_W'(PROC_ID) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         bus_req   <= 1'b0;
         bus_cmd   <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            lineState[i] <= LI;
            tagMem[i]    <= '0;
            dataMem[i]   <= '0;
         end
      end else begin
         cpu_ready <= 1'b0;
         // Local updates below are issued later, so a fill at the same index overrides a snoop.
         if (snoopAct) lineState[sIdx] <= (snoop_cmd == CMD_RD) ? LS : LI;
         case (fsm)
            IDLE: if (cpu_req && !snoopBlock) begin
               if (cHit && (!cpu_wr || lineState[cIdx][1])) begin
                  if (cpu_wr) begin
                     dataMem[cIdx]   <= cpu_wdata;
                     lineState[cIdx] <= LM;
                  end
                  cpu_rdata <= cpu_wr ? cpu_wdata : dataMem[cIdx];
                  cpu_ready <= 1'b1;
                  fsm       <= RESP;
               end else if (!cHit && lineState[cIdx] == LM) begin
                  fsm       <= WRBK;
                  bus_req   <= 1'b1;
                  bus_cmd   <= CMD_WRBK;
                  bus_addr  <= {tagMem[cIdx], cIdx};
                  bus_wdata <= dataMem[cIdx];
               end else begin
                  fsm      <= FETCH;
                  bus_req  <= 1'b1;
                  bus_cmd  <= cpu_wr ? CMD_RDX : CMD_RD;
                  bus_addr <= cpu_addr;
               end
            end
            WRBK: if (bus_gnt && bus_done) begin
               lineState[cIdx] <= LI;
               fsm             <= FETCH;
               bus_cmd         <= cpu_wr ? CMD_RDX : CMD_RD;
               bus_addr        <= cpu_addr;
               bus_wdata       <= '0;
            end
            FETCH: if (bus_gnt && bus_done) begin
               tagMem[cIdx]    <= cTag;
               dataMem[cIdx]   <= (bus_cmd == CMD_RD) ? bus_rdata : cpu_wdata;
               cpu_rdata       <= (bus_cmd == CMD_RD) ? bus_rdata : cpu_wdata;
               lineState[cIdx] <= (bus_cmd == CMD_RDX) ? LM : (EXCL && !bus_shared_in) ? LE : LS;
               cpu_ready       <= 1'b1;
               fsm             <= RESP;
               bus_req         <= 1'b0;
               bus_cmd         <= '0;
               bus_addr        <= '0;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// tb_snoop_cache_ctrl: randomized scoreboard bench for snoop_cache_ctrl with a per-line coherence model
// and a memory/arbiter responder; honours CACHE_EXCLUSIVE_EN the same way as the design.
module tb_snoop_cache_ctrl;
   localparam int NL = 16;
`ifdef CACHE_EXCLUSIVE_EN
   localparam bit EXCL = 1'b1;
`else
   localparam bit EXCL = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cpu_req, cpu_wr, cpu_ready;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        bus_req, bus_gnt, bus_done, bus_shared_in;
   logic [1:0]  bus_cmd;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [1:0]  bus_proc_id;
   logic        snoop_valid, snoop_shared, snoop_flush;
   logic [1:0]  snoop_cmd, snoop_proc_id, state_dbg;
   logic [31:0] snoop_addr, snoop_data;

   snoop_cache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_proc_id(bus_proc_id), .bus_done(bus_done),
      .bus_rdata(bus_rdata), .bus_shared_in(bus_shared_in),
      .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
      .snoop_proc_id(snoop_proc_id), .snoop_shared(snoop_shared), .snoop_flush(snoop_flush),
      .snoop_data(snoop_data), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] d; logic [1:0] st;} cpuExp_t;
   typedef struct {logic [1:0] cmd; logic [31:0] a; logic [31:0] d;} busExp_t;
   typedef struct {logic sh; logic fl; logic [31:0] d;} snpExp_t;

   cpuExp_t expCpu[$];
   busExp_t expBus[$];
   snpExp_t expSnp[$];
   cpuExp_t ce;
   busExp_t be;
   snpExp_t se;
   int errors = 0, checks = 0;
   logic [31:0] refMem [logic [31:0]];
   logic [31:0] busMem [logic [31:0]];
   logic [31:0] mAddr [NL];
   logic [31:0] mData [NL];
   logic [1:0]  mSt [NL];
   logic        shareNext = 1'b0;

   function automatic logic [31:0] memDefault(input logic [31:0] a);
      return a * 32'h0100_0193 + 32'h1234;
   endfunction

   function automatic logic [31:0] readRef(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : memDefault(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: compare whenever the DUT presents a response.
   always @(negedge clk) if (rst_n) begin
      if (cpu_ready) begin
         if (expCpu.size() == 0) check("unexpected cpu_ready", 32'(cpu_ready), 32'd0);
         else begin
            ce = expCpu.pop_front();
            check("cpu_rdata", cpu_rdata, ce.d);
            check("state_dbg", 32'(state_dbg), 32'(ce.st));
         end
      end
      if (bus_req && bus_gnt && bus_done) begin
         if (expBus.size() == 0) check("unexpected bus transaction", 32'(bus_cmd), 32'd0);
         else begin
            be = expBus.pop_front();
            check("bus_cmd", 32'(bus_cmd), 32'(be.cmd));
            check("bus_addr", bus_addr, be.a);
            if (be.cmd == 2'd3) check("bus_wdata", bus_wdata, be.d);
            check("bus_proc_id", 32'(bus_proc_id), 32'd0);
         end
      end
      if (snoop_valid) begin
         if (expSnp.size() == 0) check("unexpected snoop", 32'(snoop_valid), 32'd0);
         else begin
            se = expSnp.pop_front();
            check("snoop_shared", 32'(snoop_shared), 32'(se.sh));
            check("snoop_flush", 32'(snoop_flush), 32'(se.fl));
            if (se.fl) check("snoop_data", snoop_data, se.d);
         end
      end
   end

   // Memory + arbiter: random grant delay, spurious bus_done while not granted.
   initial begin
      int n;
      logic [31:0] a;
      bus_gnt = 1'b0; bus_done = 1'b0; bus_rdata = '0; bus_shared_in = 1'b0;
      forever begin
         tick();
         if (bus_req && rst_n) begin
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
               bus_done = ($urandom_range(0, 2) == 0);
               bus_rdata = $urandom;
               tick();
            end
            bus_done = 1'b0; bus_rdata = '0; bus_gnt = 1'b1;
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) tick();
            a = bus_addr;
            if (bus_cmd == 2'd3) busMem[a] = bus_wdata;
            bus_rdata = busMem.exists(a) ? busMem[a] : memDefault(a);
            bus_shared_in = shareNext;
            bus_done = 1'b1;
            tick();
            bus_done = 1'b0; bus_gnt = 1'b0; bus_shared_in = 1'b0; bus_rdata = '0;
         end
      end
   end

   task automatic modelReset();
      for (int i = 0; i < NL; i++) begin
         mSt[i] = 2'd0; mAddr[i] = '0; mData[i] = '0;
      end
   endtask

   task automatic modelSnoop(input logic [1:0] cmd, input logic [31:0] a, input logic [1:0] pid);
      int i;
      logic act;
      snpExp_t e;
      i = int'(a % NL);
      act = pid != 2'd0 && (cmd == 2'd1 || cmd == 2'd2) && mSt[i] != 2'd0 && mAddr[i] == a;
      e.sh = act; e.fl = act && mSt[i] == 2'd3; e.d = mData[i];
      expSnp.push_back(e);
      if (act) mSt[i] = (cmd == 2'd1) ? 2'd1 : 2'd0;
   endtask

   task automatic modelCpu(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic sh, output bit fast);
      int i;
      bit hit;
      busExp_t b;
      cpuExp_t c;
      i = int'(a % NL);
      hit = mSt[i] != 2'd0 && mAddr[i] == a;
      fast = hit && (!wr || mSt[i] >= 2'd2);
      if (hit && wr && !fast) begin
         b = '{2'd2, a, 32'd0}; expBus.push_back(b);
      end else if (!hit) begin
         if (mSt[i] == 2'd3) begin
            b = '{2'd3, mAddr[i], mData[i]}; expBus.push_back(b);
            refMem[mAddr[i]] = mData[i];
         end
         b = '{wr ? 2'd2 : 2'd1, a, 32'd0}; expBus.push_back(b);
         mAddr[i] = a;
         if (!wr) begin
            mData[i] = readRef(a);
            mSt[i] = (EXCL && !sh) ? 2'd2 : 2'd1;
         end
      end
      if (wr) begin
         mData[i] = d; mSt[i] = 2'd3;
      end
      c.d = mData[i]; c.st = mSt[i];
      expCpu.push_back(c);
   endtask

   task automatic cpuOp(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic sh,
                        input bit snp, input logic [1:0] scmd, input logic [1:0] spid);
      bit fast;
      int n;
      if (snp) modelSnoop(scmd, a, spid);
      modelCpu(wr, a, d, sh, fast);
      shareNext = sh;
      cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
      if (snp) begin
         snoop_valid = 1'b1; snoop_cmd = scmd; snoop_addr = a; snoop_proc_id = spid;
      end
      n = 0;
      while (n < 60) begin
         tick();
         snoop_valid = 1'b0;
         n++;
         if (cpu_ready) break;
      end
      cpu_req = 1'b0;
      if (!cpu_ready) check("cpu_ready timeout", 32'(cpu_ready), 32'd1);
      else if (fast && !snp) check("hit latency", 32'(n), 32'd1);
      tick();
   endtask

   task automatic snoopOp(input logic [1:0] cmd, input logic [31:0] a, input logic [1:0] pid);
      modelSnoop(cmd, a, pid);
      snoop_valid = 1'b1; snoop_cmd = cmd; snoop_addr = a; snoop_proc_id = pid;
      tick();
      snoop_valid = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] a;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      snoop_valid = 1'b0; snoop_cmd = '0; snoop_addr = '0; snoop_proc_id = '0;
      modelReset();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("reset bus_req", 32'(bus_req), 32'd0);
      check("reset bus_cmd", 32'(bus_cmd), 32'd0);
      check("reset cpu_ready", 32'(cpu_ready), 32'd0);
      check("reset cpu_rdata", cpu_rdata, 32'd0);
      check("reset state_dbg", 32'(state_dbg), 32'd0);
      check("reset bus_proc_id", 32'(bus_proc_id), 32'd0);
      check("reset snoop_shared", 32'(snoop_shared), 32'd0);
      check("reset snoop_flush", 32'(snoop_flush), 32'd0);

      refMem[32'h4] = 32'h55; busMem[32'h4] = 32'h55;
      cpuOp(1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);
      cpuOp(1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);
      cpuOp(1'b1, 32'h4, 32'hAA, 1'b0, 1'b0, 2'd0, 2'd0);
      snoopOp(2'd1, 32'h4, 2'd1);
      cpuOp(1'b1, 32'h4, 32'hBB, 1'b0, 1'b0, 2'd0, 2'd0);
      snoopOp(2'd2, 32'h4, 2'd3);
      cpuOp(1'b1, 32'h4, 32'hBB, 1'b1, 1'b0, 2'd0, 2'd0);
      cpuOp(1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);
      cpuOp(1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);
      cpuOp(1'b1, 32'h24, 32'hEE, 1'b0, 1'b1, 2'd2, 2'd1);
      cpuOp(1'b1, 32'h24, 32'hDD, 1'b0, 1'b1, 2'd2, 2'd2);
      snoopOp(2'd2, 32'h24, 2'd0);
      snoopOp(2'd3, 32'h24, 2'd1);
      cpuOp(1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0);

      for (int k = 0; k < 400; k++) begin
         n = $urandom_range(0, 9);
         a = 32'($urandom_range(0, 3) * 16 + $urandom_range(0, 7));
         if (n < 3) snoopOp(2'($urandom_range(0, 3)), a, 2'($urandom_range(0, 3)));
         else cpuOp(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                    n == 9, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      // Reset in the middle of a bus transaction.
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h1000_0005;
      n = 0;
      while (n < 20 && !bus_req) begin
         tick();
         n++;
      end
      check("bus_req before reset", 32'(bus_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("bus_req in reset", 32'(bus_req), 32'd0);
      check("cpu_ready in reset", 32'(cpu_ready), 32'd0);
      check("state_dbg in reset", 32'(state_dbg), 32'd0);
      cpu_req = 1'b0;
      expCpu.delete(); expBus.delete(); expSnp.delete();
      modelReset();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("bus_req after reset", 32'(bus_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
